// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - seven-segment glyph constants and nibble decoder
// Patterns are {a,b,c,d,e,f,g} with bit 6 = a and logic 1 = segment lit.
package sevseg_pkg;

   localparam logic [6:0] SEG_OFF = 7'b0000000;
   localparam logic [6:0] SEG_0   = 7'b1111110;
   localparam logic [6:0] SEG_1   = 7'b0110000;
   localparam logic [6:0] SEG_2   = 7'b1101101;
   localparam logic [6:0] SEG_3   = 7'b1111001;
   localparam logic [6:0] SEG_4   = 7'b0110011;
   localparam logic [6:0] SEG_5   = 7'b1011011;
   localparam logic [6:0] SEG_6   = 7'b1011111;
   localparam logic [6:0] SEG_7   = 7'b1110000;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1110011;
   localparam logic [6:0] SEG_A   = 7'b1110111;
   localparam logic [6:0] SEG_B   = 7'b0011111;
   localparam logic [6:0] SEG_C   = 7'b1001110;
   localparam logic [6:0] SEG_D   = 7'b0111101;
   localparam logic [6:0] SEG_E   = 7'b1001111;
   localparam logic [6:0] SEG_F   = 7'b1000111;

   // Codes 10-15 render as hex letters only when hexmode is set, else dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic hexmode);
      logic [6:0] pat;
      pat = SEG_OFF;
      case (nibble)
         4'h0:    pat = SEG_0;
         4'h1:    pat = SEG_1;
         4'h2:    pat = SEG_2;
         4'h3:    pat = SEG_3;
         4'h4:    pat = SEG_4;
         4'h5:    pat = SEG_5;
         4'h6:    pat = SEG_6;
         4'h7:    pat = SEG_7;
         4'h8:    pat = SEG_8;
         4'h9:    pat = SEG_9;
         4'ha:    pat = hexmode ? SEG_A : SEG_OFF;
         4'hb:    pat = hexmode ? SEG_B : SEG_OFF;
         4'hc:    pat = hexmode ? SEG_C : SEG_OFF;
         4'hd:    pat = hexmode ? SEG_D : SEG_OFF;
         4'he:    pat = hexmode ? SEG_E : SEG_OFF;
         4'hf:    pat = hexmode ? SEG_F : SEG_OFF;
         default: pat = SEG_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/sevseg_hexdec.sv
// rtl/sevseg_hexdec.sv - combinational nibble to seven-segment decoder
// Ports:
//   nibble  in  4  digit code 0..15
//   hexmode in  1  1 = show A-F for codes 10..15
//   blank   in  1  1 = force all segments dark
//   pat     out 7  {a,b,c,d,e,f,g}, logic 1 = lit
module sevseg_hexdec
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hexmode,
   input  logic       blank,
   output logic [6:0] pat
);

   assign pat = blank ? SEG_OFF : seg_decode(nibble, hexmode);

endmodule

// File: rtl/sevseg_scan_mux.sv
// rtl/sevseg_scan_mux.sv - time-multiplexed seven-segment display scanner
// Ports:
//   clk      in  1       system clock, rising edge
//   rst      in  1       synchronous active-high reset
//   en       in  1       display enable; 0 darkens outputs, scan keeps running
//   load     in  1       capture val/dp into the shadow buffer
//   val      in  4*NDIG  nibble i = digit i, digit 0 least significant
//   dp       in  NDIG    decimal point per digit
//   blanklz  in  1       blank leading zeros
//   seg      out 7       {a,b,c,d,e,f,g}, registered
//   segdp    out 1       decimal point segment, registered
//   an       out NDIG    one-hot digit enable, registered
//   frame    out 1       pulse on the cycle digit 0 of a new frame lights
module sevseg_scan_mux
   import sevseg_pkg::*;
#(
   parameter int NDIG           = 4,
   parameter int PRESCALE       = 1000,
   parameter int HEXMODE        = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [4*NDIG-1:0] val,
   input  logic [NDIG-1:0]   dp,
   input  logic              blanklz,
   output logic [6:0]        seg,
   output logic              segdp,
   output logic [NDIG-1:0]   an,
   output logic              frame
);

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = $clog2(NDIG);

   logic [PW-1:0]     pcnt;
   logic [IW-1:0]     idx;
   logic [4*NDIG-1:0] sval, dval;
   logic [NDIG-1:0]   sdp, ddp;
   logic              tc, wrap, wrap_q;
   logic [NDIG-1:0]   lz_mask;
   logic              zero_above;
   logic [3:0]        cur_nib;
   logic [6:0]        dec_pat;
   logic [NDIG-1:0]   an_next;
   logic [6:0]        seg_r;
   logic              segdp_r;
   logic [NDIG-1:0]   an_r;
   logic              frame_r;

   assign tc   = (pcnt == PW'(PRESCALE - 1));
   assign wrap = tc && (idx == IW'(NDIG - 1));

   // Digit i is a leading zero when it and every more significant digit are 0.
   // Digit 0 is never masked so an all-zero value still shows "0".
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         zero_above = zero_above & (dval[4*i +: 4] == 4'h0);
         lz_mask[i] = blanklz & zero_above;
      end
   end

   always_comb begin
      an_next      = '0;
      an_next[idx] = 1'b1;
   end

   assign cur_nib = dval[{idx, 2'b00} +: 4];

   sevseg_hexdec u_dec (
      .nibble  (cur_nib),
      .hexmode (HEXMODE != 0),
      .blank   (lz_mask[idx]),
      .pat     (dec_pat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt    <= '0;
         idx     <= '0;
         sval    <= '0;
         sdp     <= '0;
         dval    <= '0;
         ddp     <= '0;
         wrap_q  <= 1'b0;
         frame_r <= 1'b0;
         seg_r   <= SEG_OFF;
         segdp_r <= 1'b0;
         an_r    <= '0;
      end else begin
         pcnt <= tc ? '0 : pcnt + PW'(1);
         if (tc) begin
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
         end
         if (load) begin
            sval <= val;
            sdp  <= dp;
         end
         // Display buffer only changes at frame boundaries so a frame never
         // mixes old and new digits; a load on that same cycle bypasses shadow.
         if (wrap) begin
            dval <= load ? val : sval;
            ddp  <= load ? dp  : sdp;
         end
         // wrap moves idx to 0 now; the output registers show digit 0 one edge
         // later, so frame needs the same extra stage to line up with an.
         wrap_q  <= wrap;
         frame_r <= wrap_q;
         seg_r   <= en ? dec_pat : SEG_OFF;
         segdp_r <= en & ddp[idx];
         an_r    <= en ? an_next : '0;
      end
   end

   assign seg   = (SEG_ACTIVE_LOW != 0) ? ~seg_r   : seg_r;
   assign segdp = (SEG_ACTIVE_LOW != 0) ? ~segdp_r : segdp_r;
   assign an    = (AN_ACTIVE_LOW  != 0) ? ~an_r    : an_r;
   assign frame = frame_r;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// tb/tb_sevseg_scan_mux.sv - self-checking bench for sevseg_scan_mux
module tb_sevseg_scan_mux;

   localparam int ND = 4;
   localparam int P  = 4;
   localparam int F  = ND * P;

   logic        clk;
   logic        rst, en, load, blanklz;
   logic [15:0] val;
   logic [3:0]  dp;

   logic [6:0] seg0, seg1, seg2;
   logic       sdp0, sdp1, sdp2;
   logic [3:0] an0, an1, an2;
   logic       fr0, fr1, fr2;

   sevseg_scan_mux #(.NDIG(ND), .PRESCALE(P), .HEXMODE(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dp(dp), .blanklz(blanklz),
      .seg(seg0), .segdp(sdp0), .an(an0), .frame(fr0));

   sevseg_scan_mux #(.NDIG(ND), .PRESCALE(P), .HEXMODE(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_nohex (
      .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dp(dp), .blanklz(blanklz),
      .seg(seg1), .segdp(sdp1), .an(an1), .frame(fr1));

   sevseg_scan_mux #(.NDIG(ND), .PRESCALE(P), .HEXMODE(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_inv (
      .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dp(dp), .blanklz(blanklz),
      .seg(seg2), .segdp(sdp2), .an(an2), .frame(fr2));

   logic [38:0] obs;
   assign obs = {seg0, sdp0, an0, fr0, seg1, sdp1, an1, fr1, seg2, sdp2, an2, fr2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: scan position within the frame, buffered values, frame count.
   logic [6:0]  tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
   int          mpos;
   int          mframes;
   logic [15:0] msv, mdv;
   logic [3:0]  msdp, mddp;
   logic [38:0] expv;

   // One clock: outputs after the edge reflect the model state before it.
   task automatic tick();
      int          d;
      logic [15:0] rest;
      logic [3:0]  nib, ea;
      logic        bl, edp, efr;
      logic [6:0]  ph, pn, sh, sn;
      @(posedge clk);
      if (rst) begin
         expv    = {13'd0, 13'd0, 7'h7f, 1'b1, 4'hf, 1'b0};
         mpos    = 0;
         mframes = 0;
         msv     = '0;
         mdv     = '0;
         msdp    = '0;
         mddp    = '0;
      end else begin
         d    = mpos / P;
         rest = mdv >> (4 * d);
         nib  = rest[3:0];
         bl   = blanklz && (d != 0) && (rest == 16'h0);
         ph   = bl ? 7'h0 : tab[nib];
         pn   = (bl || nib > 4'd9) ? 7'h0 : tab[nib];
         sh   = en ? ph : 7'h0;
         sn   = en ? pn : 7'h0;
         ea   = en ? 4'(1 << d) : 4'h0;
         edp  = en && mddp[d];
         efr  = (mpos == 0) && (mframes > 0);
         expv = {sh, edp, ea, efr, sn, edp, ea, efr, ~sh, ~edp, ~ea, efr};
         if (mpos == F - 1) begin
            mdv  = load ? val : msv;
            mddp = load ? dp : msdp;
            mframes++;
         end
         if (load) begin
            msv  = val;
            msdp = dp;
         end
         mpos = (mpos + 1) % F;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; load = 1'b0; blanklz = 1'b0; val = 16'hffff; dp = 4'hf;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== {13'd0, 13'd0, 13'h1ffe}) begin
            errors++;
            $display("FAIL reset_const cycle %0d: got %h required %h", i, obs, {13'd0, 13'd0, 13'h1ffe});
         end
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL reset_model cycle %0d: got %h required %h", i, obs, expv);
         end
      end
      rst = 1'b0; val = 16'h0; dp = 4'h0;
   endtask

   task automatic test_scan_1234();
      int nframe = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; blanklz = 1'b0; dp = 4'h0; val = 16'h1234;
      for (int i = 0; i < 48; i++) begin
         load = (i == 0);
         tick();
         if (fr0) nframe++;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL scan_1234 cycle %0d: got %h required %h", i, obs, expv);
         end
      end
      load = 1'b0;
      checks++;
      if (nframe != 2) begin
         errors++;
         $display("FAIL frame_count: got %0d required 2", nframe);
      end
   endtask

   task automatic test_lz_hex();
      en = 1'b1; blanklz = 1'b1; dp = 4'h0; val = 16'h00a0;
      for (int i = 0; i < 40; i++) begin
         load = (i == 0);
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL lz_hex cycle %0d: got %h required %h", i, obs, expv);
         end
         if (i >= 17) begin
            checks++;
            if ((an0 == 4'b0010 && (seg0 !== 7'b1110111 || seg1 !== 7'b0000000)) ||
                (an0 == 4'b0001 && seg0 !== 7'b1111110) ||
                ((an0 == 4'b0100 || an0 == 4'b1000) && seg0 !== 7'b0000000)) begin
               errors++;
               $display("FAIL lz_hex_const an %b: got seg %b/%b", an0, seg0, seg1);
            end
         end
      end
      load = 1'b0;
   endtask

   task automatic test_zero_dp();
      en = 1'b1; blanklz = 1'b1; dp = 4'b0100; val = 16'h0000;
      for (int i = 0; i < 40; i++) begin
         load = (i == 0);
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL zero_dp cycle %0d: got %h required %h", i, obs, expv);
         end
         if (i >= 17 && an0 == 4'b0100) begin
            checks++;
            if (seg0 !== 7'b0 || sdp0 !== 1'b1) begin
               errors++;
               $display("FAIL zero_dp_digit2: got seg %b dp %b required 0000000 1", seg0, sdp0);
            end
         end
      end
      load = 1'b0; dp = 4'h0;
   endtask

   task automatic test_load_timing();
      int guard;
      en = 1'b1; blanklz = 1'b0;
      guard = 0;
      while (mpos != 6 && guard < 20) begin tick(); guard++; end
      val = 16'h5555; load = 1'b1; tick(); load = 1'b0;
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL load_mid: got %h required %h", obs, expv);
      end
      guard = 0;
      while (mpos != F - 1 && guard < 20) begin
         tick(); guard++;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL load_mid_frame: got %h required %h", obs, expv);
         end
      end
      checks++;
      if (mpos != F - 1) begin
         errors++;
         $display("FAIL load_wrap_reach: got pos %0d required %0d", mpos, F - 1);
      end
      val = 16'h9999; load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (obs !== expv || seg0 !== 7'b1110011) begin
            errors++;
            $display("FAIL load_wrap cycle %0d: got %h seg %b required %h seg 1110011", i, obs, seg0, expv);
         end
      end
   endtask

   task automatic test_enable();
      int guard = 0;
      en = 1'b1;
      while (mpos % P != 1 && guard < 8) begin tick(); guard++; end
      for (int i = 0; i < 30; i++) begin
         en = !(i >= 2 && i < 8);
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL enable cycle %0d: got %h required %h", i, obs, expv);
         end
         if (i == 2) begin
            checks++;
            if (an0 !== 4'b0 || seg0 !== 7'b0) begin
               errors++;
               $display("FAIL enable_off: got an %b seg %b required 0", an0, seg0);
            end
         end
      end
      en = 1'b1;
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      val = 16'h8765; load = 1'b1; tick(); load = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      while (mpos / P != 2 && guard < 20) begin tick(); guard++; end
      rst = 1'b1; tick();
      checks++;
      if (obs !== {13'd0, 13'd0, 13'h1ffe} || obs !== expv) begin
         errors++;
         $display("FAIL mid_reset: got %h required %h", obs, {13'd0, 13'd0, 13'h1ffe});
      end
      rst = 1'b0;
      for (int i = 0; i < 24; i++) begin
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL after_reset cycle %0d: got %h required %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst     = ($urandom_range(0, 79) == 0);
         en      = ($urandom_range(0, 7) != 0);
         load    = ($urandom_range(0, 5) == 0);
         blanklz = $urandom_range(0, 1) != 0;
         val     = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         dp      = 4'($urandom);
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL random cycle %0d: got %h required %h", i, obs, expv);
         end
      end
      rst = 1'b0; load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; blanklz = 1'b0; val = '0; dp = '0;
      mpos = 0; mframes = 0; msv = '0; mdv = '0; msdp = '0; mddp = '0; expv = '0;
      test_reset();
      test_scan_1234();
      test_lz_hex();
      test_zero_dp();
      test_load_timing();
      test_enable();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sevseg_scan_mux.md
# sevseg_scan_mux

Time-multiplexed driver for an NDIG-digit common-anode/cathode seven-segment display. It accepts a packed BCD/hex value, double-buffers it so a frame never tears, and scans one digit per PRESCALE clocks. Each digit is decoded to abcdefg plus a decimal point, with optional hex glyphs and leading-zero blanking. It replaces per-digit static decoders wherever a board shares segment lines across digits.

## Interface
Parameters:
- NDIG, 4: digit count, 2..8.
- PRESCALE, 1000: clocks each digit stays lit, ≥2.
- HEXMODE, 1: 1 = codes 10–15 show A b C d E F; 0 = codes 10–15 blank.
- SEG_ACTIVE_LOW, 0: 1 = SEG/SEGDP inverted at output.
- AN_ACTIVE_LOW, 0: 1 = AN inverted at output.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  display enable; 0 forces all outputs inactive, scan keeps running.
- LOAD  in  1  capture VAL/DP into shadow register this cycle.
- VAL  in  4*NDIG  nibble i = digit i, digit 0 least significant.
- DP  in  NDIG  decimal point per digit.
- BLANKLZ  in  1  1 = blank leading zeros.
- SEG  out  7  {a,b,c,d,e,f,g}, SEG[6]=a; registered.
- SEGDP  out  1  decimal point segment; registered.
- AN  out  NDIG  one-hot digit enable; registered.
- FRAME  out  1  one-cycle pulse when scan wraps to digit 0.

## Operation
- Prescaler PCNT counts 0..PRESCALE-1; terminal count TC when PCNT = PRESCALE-1.
- On TC: IDX advances, IDX = NDIG-1 wraps to 0 (wrap event).
- Shadow {SVAL,SDP} loads from {VAL,DP} on LOAD. Display {DVAL,DDP} loads from shadow on wrap event only.
- LOAD on a wrap cycle: shadow and display both take VAL/DP (bypass), so new data is displayed from the next frame start.
- Decode (logic-1 = lit): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011; HEXMODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; HEXMODE=0: 10–15 → 0000000. No X ever driven.
- Leading-zero blanking: digit i is blanked when BLANKLZ=1, all DVAL nibbles i..NDIG-1 are 0, and i≠0. Digit 0 is always shown. DP is never blanked.
- EN=0: SEG, SEGDP = inactive; AN = all inactive. PCNT, IDX, and the buffers keep operating.
- Output polarity inversion is applied after the output register. "Inactive" means 0 before inversion.

## Timing
- Reset values: PCNT=0, IDX=0, SVAL/DVAL=0, SDP/DDP=0, SEG/SEGDP/AN inactive, FRAME=0.
- Outputs are registered: SEG/SEGDP/AN reflect IDX/DVAL/EN of the previous cycle, giving 1-cycle latency.
- First cycle after RST release with EN=1: outputs still reset. Second cycle: AN selects digit 0.
- Each digit is lit exactly PRESCALE cycles; the frame is NDIG*PRESCALE cycles.
- FRAME is registered and high the cycle AN first selects digit 0 of a new frame. It is not asserted for the post-reset start.
- LOAD→display latency: until the next wrap event, plus 1 cycle.
- RST mid-frame: all state returns to reset values on the next edge; the shadow is lost.
- EN toggle: takes effect on outputs 1 cycle later and does not disturb scan phase.

## Structure
- Package sevseg_pkg: 7-bit segment pattern constants for 0–F, constant SEG_OFF, function seg_decode(nibble, hexmode).
- Sub-module sevseg_hexdec: combinational nibble+hexmode+blank → 7-bit pattern, instantiated once on the selected digit.
- Top holds prescaler, IDX counter, shadow/display registers, LZ-blank mask, and output registers.

## Test plan
- NDIG=4, PRESCALE=4, after RST, EN=1, LOAD VAL=16'h1234 → after first wrap, AN cycles 0001,0010,0100,1000, each for 4 cycles; SEG = 0110011 (4), 1111001, 1101101, 0110000; FRAME pulses every 16 cycles.
- VAL=16'h00A0, BLANKLZ=1, HEXMODE=1 → digits 3,2 SEG=0000000, digit 1=1110111, digit 0=1111110. With HEXMODE=0, digit 1=0000000.
- VAL=16'h0000, BLANKLZ=1, DP=4'b0100 → digits 3,1 dark; digit 2 SEG dark but SEGDP=1; digit 0 shows 1111110.
- LOAD 16'h5555 mid-frame → current frame unchanged. LOAD 16'h9999 on the wrap cycle → next frame shows 9 (1110011) on all digits.
- EN=0 for 6 cycles mid-digit → SEG/AN inactive 1 cycle after EN falls. Scan phase is preserved: FRAME timing is unchanged.
- RST during digit 2; SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 → SEG=1111111, SEGDP=1, AN=1111 next cycle; old VAL is not shown after release.
